// File: rtl/pr_icap_writer.sv
// Streams a 32-bit partial bitstream into the ICAPE3 write port, then waits for PRDONE/PRERROR
// with a timeout and reports one completion or error event.
module pr_icap_writer #(
    parameter bit          BIT_SWAP       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        icap_clk,
    input  logic        icap_rstn,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    input  logic [3:0]  icap_pr_status,
    output logic        icap_csib,
    output logic        icap_rdwrb,
    output logic [31:0] icap_din,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [31:0] word_count
);

    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrPr      = 2'd1;
    localparam logic [1:0] ErrTimeout = 2'd2;
    localparam logic [1:0] ErrAbort   = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StStream,
        StDrain,
        StWaitPr,
        StDone,
        StError
    } state_e;

    state_e      state_q, state_d;
    logic        csib_q, csib_d;
    logic        rdwrb_q, rdwrb_d;
    logic [31:0] din_q, din_d;
    logic [31:0] wc_q, wc_d;
    logic [1:0]  err_q, err_d;
    logic        abort_pend_q, abort_pend_d;
    logic [31:0] tmo_q, tmo_d;

    logic prdone;
    logic avail;
    logic prerror;
    logic unused_status;

    assign prdone        = icap_pr_status[0];
    assign avail         = icap_pr_status[1];
    assign prerror       = icap_pr_status[2];
    assign unused_status = icap_pr_status[3];

    function automatic logic [7:0] rev8(input logic [7:0] b);
        return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
    endfunction

    function automatic logic [31:0] icap_swap(input logic [31:0] w);
        return {rev8(w[31:24]), rev8(w[23:16]), rev8(w[15:8]), rev8(w[7:0])};
    endfunction

    always_comb begin
        state_d      = state_q;
        csib_d       = 1'b1;
        rdwrb_d      = rdwrb_q;
        din_d        = din_q;
        wc_d         = wc_q;
        err_d        = err_q;
        abort_pend_d = abort_pend_q;
        tmo_d        = tmo_q;
        s_tready     = 1'b0;

        unique case (state_q)
            StIdle: begin
                rdwrb_d = 1'b1;
                if (start && !abort) begin
                    state_d      = StArm;
                    wc_d         = '0;
                    err_d        = ErrNone;
                    abort_pend_d = 1'b0;
                end
            end
            StArm: begin
                // RDWRB settles here so it never moves while CSIB is low.
                rdwrb_d = 1'b0;
                if (abort) begin
                    abort_pend_d = 1'b1;
                    state_d      = StDrain;
                end else begin
                    state_d = StStream;
                end
            end
            StStream: begin
                s_tready = avail & ~abort;
                if (abort) begin
                    abort_pend_d = 1'b1;
                    state_d      = StDrain;
                end else if (s_tvalid && s_tready) begin
                    csib_d = 1'b0;
                    din_d  = BIT_SWAP ? icap_swap(s_tdata) : s_tdata;
                    wc_d   = wc_q + 32'd1;
                    if (s_tlast) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                rdwrb_d = 1'b1;
                tmo_d   = '0;
                if (abort_pend_q) begin
                    err_d   = ErrAbort;
                    state_d = StError;
                end else begin
                    state_d = StWaitPr;
                end
            end
            StWaitPr: begin
                tmo_d = tmo_q + 32'd1;
                if (prerror) begin
                    err_d   = ErrPr;
                    state_d = StError;
                end else if (prdone) begin
                    state_d = StDone;
                end else if (tmo_q == TimeoutLast) begin
                    err_d   = ErrTimeout;
                    state_d = StError;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StError: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge icap_clk or negedge icap_rstn) begin
        if (!icap_rstn) begin
            state_q      <= StIdle;
            csib_q       <= 1'b1;
            rdwrb_q      <= 1'b1;
            din_q        <= '0;
            wc_q         <= '0;
            err_q        <= ErrNone;
            abort_pend_q <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            csib_q       <= csib_d;
            rdwrb_q      <= rdwrb_d;
            din_q        <= din_d;
            wc_q         <= wc_d;
            err_q        <= err_d;
            abort_pend_q <= abort_pend_d;
            tmo_q        <= tmo_d;
        end
    end

    assign icap_csib  = csib_q;
    assign icap_rdwrb = rdwrb_q;
    assign icap_din   = din_q;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign error      = (state_q == StError);
    assign err_code   = err_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_pr_icap_writer.sv
// Randomized bench for pr_icap_writer: a transaction-level model predicts ICAP writes from
// observed handshakes and the completion event from each load's scenario.
module tb_pr_icap_writer;

    localparam int TimeoutCycles = 16;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        abort;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic        prdone;
    logic        prerror;
    logic        avail;
    logic        icap_csib;
    logic        icap_rdwrb;
    logic [31:0] icap_din;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [31:0] word_count;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] writes[$];
    logic [31:0] load_words[$];
    logic [31:0] tv_exp[4];
    logic        v_busy[7];
    logic        v_csib[7];
    logic        v_rdwrb[7];
    logic        v_done[7];
    logic        v_tready[7];
    int          r_n, r_ab, r_gap, r_pm, r_d, rs_idx, dn_rst, er_rst;

    pr_icap_writer #(
        .BIT_SWAP      (1'b1),
        .TIMEOUT_CYCLES(TimeoutCycles)
    ) dut (
        .icap_clk      (clk),
        .icap_rstn     (rstn),
        .start         (start),
        .abort         (abort),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tlast       (s_tlast),
        .s_tready      (s_tready),
        .icap_pr_status({1'b0, prerror, avail, prdone}),
        .icap_csib     (icap_csib),
        .icap_rdwrb    (icap_rdwrb),
        .icap_din      (icap_din),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_code      (err_code),
        .word_count    (word_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Bit order reversed within each byte: reverse the whole word, then undo the byte reversal.
    function automatic logic [31:0] swap_ref(input logic [31:0] w);
        logic [31:0] rv;
        rv = {<<{w}};
        return {<<8{rv}};
    endfunction

    always @(negedge clk) begin
        if (rstn) begin
            logic have;
            check_eq("tready_gate", 32'(s_tready & ~(avail & ~abort)), 32'd0);
            check_eq("done_error_excl", 32'(done & error), 32'd0);
            if (s_tready) check_eq("rdwrb_while_ready", 32'(icap_rdwrb), 32'd0);
            if (!icap_csib) begin
                have = (exp_q.size() > 0);
                check_eq("rdwrb_on_write", 32'(icap_rdwrb), 32'd0);
                check_eq("write_has_accept", 32'(have), 32'd1);
                if (have) check_eq("write_data", icap_din, exp_q.pop_front());
                writes.push_back(icap_din);
            end
            if (s_tvalid && s_tready) exp_q.push_back(swap_ref(s_tdata));
            if (done) done_cnt++;
            if (error) err_cnt++;
        end
    end

    task automatic check_idle_outputs();
        check_eq("rst_csib", 32'(icap_csib), 32'd1);
        check_eq("rst_rdwrb", 32'(icap_rdwrb), 32'd1);
        check_eq("rst_din", icap_din, 32'd0);
        check_eq("rst_tready", 32'(s_tready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_err_code", 32'(err_code), 32'd0);
        check_eq("rst_word_count", word_count, 32'd0);
    endtask

    task automatic fill_words(input int n);
        load_words.delete();
        for (int i = 0; i < n; i++) load_words.push_back($urandom);
    endtask

    // vmode: 0 always valid, 1 valid every other cycle, 2 random.
    // pr_mode: 0 prdone after pr_delay, 1 prerror+prdone after pr_delay, 2 silent (timeout).
    task automatic do_load(input int n, input int vmode, input int gap_at, input int abort_at,
                           input int pr_mode, input int pr_delay, input bit start_busy);
        int idx, abort_t, gap_left, k_hit, dn0, er0, exp_wc, exp_k;
        bit aborting, gap_done, sb_done, seen, got_done, exp_done;
        logic [1:0] code, exp_code;
        idx = 0; abort_t = -1; gap_left = 0; k_hit = -1;
        aborting = 0; gap_done = 0; sb_done = 0; seen = 0; got_done = 0; code = 2'd0;
        exp_q.delete();
        writes.delete();
        dn0 = done_cnt;
        er0 = err_cnt;

        if (abort_at >= 0) begin
            exp_wc = abort_at; exp_done = 0; exp_code = 2'd3; exp_k = 1;
        end else begin
            exp_wc = n;
            case (pr_mode)
                0:       begin exp_done = 1; exp_code = 2'd0; exp_k = pr_delay + 1; end
                1:       begin exp_done = 0; exp_code = 2'd1; exp_k = pr_delay + 1; end
                default: begin exp_done = 0; exp_code = 2'd2; exp_k = TimeoutCycles + 1; end
            endcase
        end

        s_tvalid = 0; s_tlast = 0; avail = 1; prdone = 0; prerror = 0;
        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        start = 0;

        for (int t = 0; t < 400; t++) begin
            if (abort_at >= 0 && idx == abort_at && !aborting) begin
                abort = 1; aborting = 1; abort_t = t;
            end
            if (gap_at >= 0 && idx == gap_at && !gap_done) begin
                gap_left = 3; gap_done = 1;
            end
            avail = (gap_left == 0);
            if (gap_left > 0) gap_left--;
            start = start_busy && (idx == 1) && !sb_done;
            if (start) sb_done = 1;
            s_tdata = load_words[idx];
            s_tlast = (idx == n - 1);
            case (vmode)
                0:       s_tvalid = 1;
                1:       s_tvalid = ((t % 2) == 0);
                default: s_tvalid = ($urandom_range(0, 2) != 0);
            endcase
            if (aborting) s_tvalid = 1;
            @(negedge clk);
            if (aborting) check_eq("abort_tready", 32'(s_tready), 32'd0);
            if (s_tvalid && s_tready) idx++;
            @(posedge clk); #1;
            if (aborting || idx == n) break;
        end
        check_eq("stream_progress", idx, (abort_at >= 0) ? abort_at : n);

        s_tvalid = 0; s_tlast = 0; start = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            prdone  = (pr_mode != 2) && (k >= pr_delay);
            prerror = (pr_mode == 1) && (k >= pr_delay);
            if (k == 0) abort = 0;
            @(negedge clk);
            if (k == 0 && abort_t >= 0) check_eq("abort_csib_next", 32'(icap_csib), 32'd1);
            if (done || error) begin
                seen = 1; k_hit = k; got_done = done; code = err_code;
            end
            @(posedge clk); #1;
        end

        check_eq("completion_seen", 32'(seen), 32'd1);
        check_eq("pulse_is_done", 32'(got_done), 32'(exp_done));
        check_eq("pulse_cycle", k_hit, exp_k);
        check_eq("err_code_pulse", 32'(code), 32'(exp_code));
        prdone = 0; prerror = 0; avail = 1;
        @(negedge clk);
        check_eq("busy_after", 32'(busy), 32'd0);
        check_eq("err_code_held", 32'(err_code), 32'(exp_code));
        check_eq("word_count", word_count, exp_wc);
        check_eq("writes_seen", writes.size(), exp_wc);
        check_eq("accepts_flushed", exp_q.size(), 32'd0);
        check_eq("done_pulses", done_cnt - dn0, exp_done ? 1 : 0);
        check_eq("error_pulses", err_cnt - er0, exp_done ? 0 : 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rstn = 1; start = 0; abort = 0; s_tdata = 0; s_tvalid = 0; s_tlast = 0;
        prdone = 0; prerror = 0; avail = 1;
        #2 rstn = 0;
        #1 check_idle_outputs();
        repeat (3) @(posedge clk);
        #1 rstn = 1;

        // Minimum load: single tlast word with prdone already high.
        prdone = 1;
        @(posedge clk); #1;
        start = 1; s_tvalid = 1; s_tlast = 1; s_tdata = 32'h0000_00f1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            v_busy[i] = busy; v_csib[i] = icap_csib; v_rdwrb[i] = icap_rdwrb;
            v_done[i] = done; v_tready[i] = s_tready;
            @(posedge clk); #1;
            start = 0;
            if (i == 2) begin s_tvalid = 0; s_tlast = 0; end
        end
        prdone = 0;
        check_eq("min_busy_arm", 32'(v_busy[1]), 32'd1);
        check_eq("min_tready_arm", 32'(v_tready[1]), 32'd0);
        check_eq("min_tready_stream", 32'(v_tready[2]), 32'd1);
        check_eq("min_csib_accept", 32'(v_csib[2]), 32'd1);
        check_eq("min_csib_write", 32'(v_csib[3]), 32'd0);
        check_eq("min_rdwrb_write", 32'(v_rdwrb[3]), 32'd0);
        check_eq("min_rdwrb_wait", 32'(v_rdwrb[4]), 32'd1);
        check_eq("min_done_early", 32'(v_done[4]), 32'd0);
        check_eq("min_done_pulse", 32'(v_done[5]), 32'd1);
        check_eq("min_busy_done", 32'(v_busy[5]), 32'd1);
        check_eq("min_busy_idle", 32'(v_busy[6]), 32'd0);
        check_eq("min_word_count", word_count, 32'd1);

        // Reference bitstream header.
        load_words.delete();
        load_words.push_back(32'hFFFF_FFFF);
        load_words.push_back(32'hAA99_5566);
        load_words.push_back(32'h2000_0000);
        load_words.push_back(32'h3000_8001);
        tv_exp[0] = 32'hFFFF_FFFF;
        tv_exp[1] = 32'h5599_AA66;
        tv_exp[2] = 32'h0400_0000;
        tv_exp[3] = 32'h0C00_0180;
        do_load(4, 0, -1, -1, 0, 10, 1'b0);
        for (int i = 0; i < 4; i++) check_eq("tv_din", writes[i], tv_exp[i]);

        fill_words(8);
        do_load(8, 1, 3, -1, 0, 2, 1'b0);
        fill_words(3);
        do_load(3, 0, -1, -1, 1, 4, 1'b0);
        fill_words(2);
        do_load(2, 0, -1, -1, 2, 1, 1'b0);
        fill_words(5);
        do_load(5, 0, -1, 2, 0, 3, 1'b1);

        // Reset in the middle of a stream, then a fresh load.
        fill_words(6);
        exp_q.delete();
        dn_rst = done_cnt; er_rst = err_cnt; rs_idx = 0;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        s_tvalid = 1;
        for (int t = 0; t < 50 && rs_idx < 2; t++) begin
            s_tdata = load_words[rs_idx];
            @(negedge clk);
            if (s_tvalid && s_tready) rs_idx++;
            @(posedge clk); #1;
        end
        #2 rstn = 0;
        #1 check_idle_outputs();
        s_tvalid = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_no_done", done_cnt, dn_rst);
        check_eq("rst_no_error", err_cnt, er_rst);
        rstn = 1;
        exp_q.delete();
        fill_words(5);
        do_load(5, 2, -1, -1, 0, 1, 1'b0);

        for (int r = 0; r < 10; r++) begin
            r_n   = $urandom_range(1, 12);
            r_ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, r_n - 1) : -1;
            r_gap = ($urandom_range(0, 1) == 1) ? $urandom_range(0, r_n - 1) : -1;
            r_pm  = $urandom_range(0, 2);
            r_d   = $urandom_range(1, 12);
            fill_words(r_n);
            do_load(r_n, 2, r_gap, r_ab, r_pm, r_d, (r % 2) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pr_icap_writer.md
# pr_icap_writer

Bitstream streamer that sits directly upstream of the ICAPE3 wrapper in the shell's partial-reconfiguration path. It accepts a 32-bit partial bitstream as a valid/ready stream, applies the ICAP per-byte bit swap, and drives the ICAP write port (CSIB/RDWRB/I) while honouring AVAIL. After the last word it watches PRDONE/PRERROR with a timeout and reports a single completion or error event to the shell controller.

## Interface
- BIT_SWAP, 1: when 1, reverse bit order within each byte of every word before driving ICAP; when 0, pass words through unchanged
- TIMEOUT_CYCLES, 1000000: cycles allowed in WAIT_PR for PRDONE/PRERROR; 32-bit, must be ≥ 1
- icap_clk  in  1  sole clock, same clock as the ICAP primitive
- icap_rstn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a load; honoured only in IDLE
- abort  in  1  level; cancels a load in ARM/STREAM
- s_tdata  in  32  bitstream word
- s_tvalid  in  1  word valid
- s_tlast  in  1  marks the final word of the bitstream
- s_tready  out  1  word accepted when s_tvalid & s_tready
- icap_pr_status  in  4  {0, prerror, avail, prdone} from the ICAP wrapper
- icap_csib  out  1  ICAP chip select, active low
- icap_rdwrb  out  1  ICAP direction, 0 = write
- icap_din  out  32  ICAP write data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful completion
- error  out  1  one-cycle pulse on failure
- err_code  out  2  0 none, 1 PRERROR, 2 timeout, 3 abort; held until the next start
- word_count  out  32  words written in the current or last load; cleared on start

## Operation
- States: IDLE, ARM, STREAM, DRAIN, WAIT_PR, DONE, ERROR.
- IDLE: csib=1, rdwrb=1, s_tready=0. start=1 & abort=0 -> ARM, word_count←0, err_code←0. start & abort in the same cycle -> stay in IDLE.
- ARM (exactly 1 cycle): rdwrb←0 while csib stays 1, so RDWRB never changes while CSIB is low. abort -> DRAIN with err_code 3 pending; otherwise -> STREAM.
- STREAM: s_tready = avail & ~abort. On an accept: next cycle csib=0, icap_din = swap(s_tdata), word_count+1. On a non-accept cycle: next cycle csib=1 and icap_din holds its previous value. An accept with s_tlast -> DRAIN. abort -> DRAIN with err_code 3 pending; the word offered in that cycle is not accepted.
- DRAIN (1 cycle): csib=1, rdwrb stays 0. Next cycle rdwrb=1. Pending abort -> ERROR; otherwise -> WAIT_PR with timeout counter←0.
- WAIT_PR: counter increments each cycle. Exit priority: prerror -> ERROR (code 1); else prdone -> DONE; else counter == TIMEOUT_CYCLES-1 -> ERROR (code 2). avail and abort are ignored here.
- DONE / ERROR (1 cycle each): pulse done or error respectively, then -> IDLE.
- Swap: for each byte, out[8k+j] = in[8k+7-j].
- word_count wraps modulo 2^32.

## Timing
- Reset values: icap_csib=1, icap_rdwrb=1, icap_din=0, s_tready=0, busy=0, done=0, error=0, err_code=0, word_count=0. All state and counters return to these asynchronously.
- Reset asserted mid-load: outputs return to reset values immediately, csib is released, and no done/error pulse is generated.
- icap_csib, icap_rdwrb and icap_din are registered. Latency from stream accept to the ICAP write cycle is 1 clock.
- s_tready is combinational from state, avail and abort; no other input reaches it.
- Minimum load (single tlast word, prdone already high): start@0, ARM@1, accept@2, csib=0@3, DRAIN@3, WAIT_PR@4 with rdwrb=1, DONE@5, done pulse@5, busy=0@6.
- avail dropping mid-stream stalls the stream: csib=1 from the next cycle, and no data is lost.

## Test plan
- Stream of 4 words 0xFFFFFFFF, 0xAA995566, 0x20000000, 0x30008001 (last), BIT_SWAP=1, prdone asserted 10 cycles later -> icap_din sequence FFFFFFFF, 5599AA66, 04000000, 0C000180, each with csib=0 for one cycle; word_count=4; one done pulse; err_code=0.
- s_tvalid toggled every other cycle and avail held low for 3 cycles mid-stream -> csib high on every gap, no word dropped or duplicated, rdwrb=0 continuously from ARM through DRAIN.
- prerror asserted in WAIT_PR together with prdone -> error pulse with err_code=1, no done pulse.
- TIMEOUT_CYCLES=16, no prdone -> error exactly 16 cycles after entering WAIT_PR, err_code=2.
- abort after the 2nd word -> s_tready=0 that cycle, csib=1 next cycle, error with err_code=3, word_count=2. start while busy is ignored.
- icap_rstn asserted during STREAM -> all outputs at reset values immediately. A fresh start after release completes normally with word_count restarting at 0.
